feature_serializer: RTL and testbench
=====================================

FEATURE_SERIALIZER -- requirements
Module: feature_serializer

Interface
REQ-001 Parameter NUM_FEAT, default 20, number of 32-bit features per frame.
REQ-002 Parameter DATA_W, default 32, feature width in bits.
REQ-003 Parameter NORM_SHIFT, default 4, arithmetic right-shift applied when FEAT_NORM_EN is defined.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  capture enable; low blocks new frame capture only.
REQ-007 dwt_valid  input  1  level flag from the DWT stage; high while the feature set is valid.
REQ-008 feat_vec  input  NUM_FEAT*DATA_W  packed signed features, index 0 in LSBs; order is gamma max/min/mean/sum, then beta, alpha, theta, delta.
REQ-009 feat_data  output  DATA_W  current signed feature word.
REQ-010 feat_idx  output  5  index of feat_data within the frame.
REQ-011 feat_valid  output  1  feat_data/feat_idx/feat_last are valid.
REQ-012 feat_ready  input  1  downstream accepts the word.
REQ-013 feat_last  output  1  high with the word at index NUM_FEAT-1.
REQ-014 busy  output  1  high while a frame is held or streaming.
REQ-015 overrun  output  1  sticky flag: a frame was dropped.

Function
REQ-016 The block SHALL register dwt_valid and define rise = dwt_valid & ~dwt_valid_q.
REQ-017 The FSM SHALL have states IDLE and STREAM.
REQ-018 In IDLE with rise & en, the block SHALL capture feat_vec into a NUM_FEAT x DATA_W snapshot, clear the index to 0, and enter STREAM on the same edge.
REQ-019 feat_valid SHALL be high exactly while in STREAM; first word is visible the cycle after the capturing rise (latency 1).
REQ-020 A transfer occurs on a clock edge with feat_valid & feat_ready; the index SHALL increment by 1 per transfer.
REQ-021 feat_data and feat_idx SHALL hold stable while feat_valid & ~feat_ready; feat_valid SHALL NOT drop before its transfer.
REQ-022 On the transfer at index NUM_FEAT-1, the FSM SHALL return to IDLE; a full frame takes NUM_FEAT transfer cycles minimum.
REQ-023 A rise in STREAM, or in the same cycle as the last transfer, SHALL NOT recapture and SHALL set overrun; the current frame continues unaltered.
REQ-024 rise with en low SHALL be ignored without setting overrun.
REQ-025 A dwt_valid held high SHALL produce exactly one capture; re-capture requires a low-then-high transition.
REQ-026 busy SHALL equal (state == STREAM).
REQ-027 The index SHALL never exceed NUM_FEAT-1 (no wrap-around inside a frame).

Reset
REQ-028 On rst the block SHALL force: state IDLE, feat_valid 0, feat_last 0, feat_idx 0, feat_data 0, busy 0, overrun 0, dwt_valid_q 0, and snapshot all-zero.
REQ-029 rst mid-frame SHALL abandon the frame immediately; no further words emitted.
REQ-030 overrun SHALL be cleared only by rst.

Configuration
REQ-031 With FEAT_NORM_EN defined, feat_data SHALL be snapshot[idx] >>> NORM_SHIFT (arithmetic, sign preserved).
REQ-032 Without FEAT_NORM_EN, feat_data SHALL be snapshot[idx] unmodified.

Structure
REQ-033 Package bci_feat_pkg SHALL hold NUM_FEAT, DATA_W, the feature-index enum (GAMMA_MAX .. DELTA_SUM), and the FSM state enum.
REQ-034 One sub-module, feat_snapshot (capture register bank with indexed read), is natural; the FSM and handshake stay in the top.

Verification
REQ-035 Features k=0..19 set to 100+k, dwt_valid rises, feat_ready=1 -> 20 consecutive words 100..119, idx 0..19, feat_last only on 119, busy drops after it.
REQ-036 feat_ready toggled 1,0,0,1 pattern -> each word held stable while stalled; no word lost or duplicated; order 0..19.
REQ-037 Second dwt_valid rise at word 5 -> overrun=1, remaining words still from the first frame; overrun stays 1 until rst.
REQ-038 FEAT_NORM_EN defined, NORM_SHIFT=4, feature -256 -> feat_data -16; feature 255 -> 15; undefined -> -256 and 255.
REQ-039 rst asserted at word 10 -> all outputs 0 next cycle; new rise after reset release restarts at idx 0.
REQ-040 dwt_valid held high 100 cycles with en=1 -> exactly one frame; rise with en=0 -> no frame, overrun=0.

Source files
------------

// File: rtl/bci_feat_pkg.sv
// Shared definitions for the BCI feature serializer: frame geometry,
// feature ordering inside a frame, and the serializer FSM states.
package bci_feat_pkg;

    localparam int NUM_FEAT = 20;
    localparam int DATA_W   = 32;
    localparam int IDX_W    = 5;

    // Frame order: per band max/min/mean/sum, bands gamma, beta, alpha, theta, delta.
    typedef enum logic [IDX_W-1:0] {
        GAMMA_MAX, GAMMA_MIN, GAMMA_MEAN, GAMMA_SUM,
        BETA_MAX,  BETA_MIN,  BETA_MEAN,  BETA_SUM,
        ALPHA_MAX, ALPHA_MIN, ALPHA_MEAN, ALPHA_SUM,
        THETA_MAX, THETA_MIN, THETA_MEAN, THETA_SUM,
        DELTA_MAX, DELTA_MIN, DELTA_MEAN, DELTA_SUM
    } feat_idx_e;

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

endpackage

// File: rtl/feat_snapshot.sv
// Capture register bank: latches a whole feature frame in one cycle and
// serves one word at a time through an indexed read port.
module feat_snapshot
    import bci_feat_pkg::*;
#(
    parameter int NUM_FEAT = bci_feat_pkg::NUM_FEAT,
    parameter int DATA_W   = bci_feat_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_cap,
    input  logic [NUM_FEAT*DATA_W-1:0] i_vec,
    input  logic [IDX_W-1:0]           i_idx,
    output logic [DATA_W-1:0]          o_word
);

    logic [NUM_FEAT-1:0][DATA_W-1:0] r_bank;

    // Snapshot the full frame on capture; otherwise hold so the stream is stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_bank <= '0;
        else if (i_cap) r_bank <= i_vec;
    end

    // The serializer never drives an index past NUM_FEAT-1.
    assign o_word = r_bank[i_idx];

endmodule

// File: rtl/feature_serializer.sv
// Feature serializer: on a rising edge of dwt_valid (with en) snapshots a
// frame of NUM_FEAT signed features and streams them out one word per
// valid/ready transfer. Rises that arrive while a frame is in flight are
// dropped and latched in the sticky overrun flag.
// Optional build macro FEAT_NORM_EN: arithmetic right shift of each output
// word by NORM_SHIFT.
module feature_serializer
    import bci_feat_pkg::*;
#(
    parameter int NUM_FEAT   = bci_feat_pkg::NUM_FEAT,
    parameter int DATA_W     = bci_feat_pkg::DATA_W,
    parameter int NORM_SHIFT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       dwt_valid,
    input  logic [NUM_FEAT*DATA_W-1:0] feat_vec,
    output logic [DATA_W-1:0]          feat_data,
    output logic [IDX_W-1:0]           feat_idx,
    output logic                       feat_valid,
    input  logic                       feat_ready,
    output logic                       feat_last,
    output logic                       busy,
    output logic                       overrun
);

`ifdef FEAT_NORM_EN
    localparam int NORM_ON = 1;
`else
    localparam int NORM_ON = 0;
`endif
    localparam int              SHIFT_AMT = NORM_SHIFT * NORM_ON;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEAT - 1);

    state_e            r_state, w_state_nxt;
    logic              r_dwt_q;
    logic [IDX_W-1:0]  r_idx;
    logic              r_overrun;
    logic              w_rise, w_cap, w_xfer, w_at_last;
    logic [DATA_W-1:0] w_word;

    assign w_rise    = dwt_valid & ~r_dwt_q;
    assign w_at_last = (r_idx == IDX_LAST);

    // Delayed copy of dwt_valid for edge detection; a held-high level yields one rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_dwt_q <= 1'b0;
        else     r_dwt_q <= dwt_valid;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state plus capture/transfer strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise && en) begin
                    w_cap       = 1'b1;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (feat_ready) begin
                    w_xfer = 1'b1;
                    if (w_at_last) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Word index: cleared on capture, advanced per transfer, parked at 0 after the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_idx <= '0;
        else if (w_cap)  r_idx <= '0;
        else if (w_xfer) r_idx <= w_at_last ? '0 : r_idx + IDX_W'(1);
    end

    // Sticky drop flag: an enabled rise while streaming (including the last-word cycle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    r_overrun <= 1'b0;
        else if (w_rise && en && r_state == STREAM) r_overrun <= 1'b1;
    end

    feat_snapshot #(
        .NUM_FEAT (NUM_FEAT),
        .DATA_W   (DATA_W)
    ) u_snap (
        .clk    (clk),
        .rst    (rst),
        .i_cap  (w_cap),
        .i_vec  (feat_vec),
        .i_idx  (r_idx),
        .o_word (w_word)
    );

    // A shift of zero leaves the word untouched when normalization is not built in.
    assign feat_data  = DATA_W'($signed(w_word) >>> SHIFT_AMT);
    assign feat_idx   = r_idx;
    assign feat_valid = (r_state == STREAM);
    assign feat_last  = feat_valid & w_at_last;
    assign busy       = (r_state == STREAM);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_feature_serializer.sv
// Self-checking bench for feature_serializer: frames of known or random
// features are pushed in and every streamed word is compared against a
// frame-level reference (expected word k = feature k, optionally shifted).
module tb_feature_serializer;

    localparam int NF = 20;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           dwt_valid = 1'b0;
    logic           feat_ready = 1'b0;
    logic [NF*DW-1:0] feat_vec = '0;
    logic [DW-1:0]  feat_data;
    logic [4:0]     feat_idx;
    logic           feat_valid, feat_last, busy, overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic signed [DW-1:0] frame [NF];

    feature_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dwt_valid  (dwt_valid),
        .feat_vec   (feat_vec),
        .feat_data  (feat_data),
        .feat_idx   (feat_idx),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .feat_last  (feat_last),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model_word(input logic signed [DW-1:0] x);
`ifdef FEAT_NORM_EN
        return DW'(x >>> 4);
`else
        return x;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_frame();
        for (int k = 0; k < NF; k++) frame[k] = $urandom;
    endtask

    // Load the reference frame onto feat_vec and give dwt_valid one rising edge.
    task automatic start_frame();
        for (int k = 0; k < NF; k++) feat_vec[k*DW +: DW] = frame[k];
        en = 1'b1;
        dwt_valid = 1'b1;
        tick();
        dwt_valid = 1'b0;
    endtask

    // Consume one frame; mode 0 ready always, 1 ready pattern 1,0,0,1, 2 random.
    // rise_at >= 0 raises dwt_valid (with a different feat_vec) from that word on.
    task automatic drain(input string nm, input int mode, input int rise_at);
        int k = 0;
        int cyc = 0;
        logic rdy;
        logic [DW+7:0] got, exp;
        while (k < NF && cyc < 300) begin
            case (mode)
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b1;
            endcase
            feat_ready = rdy;
            if (rise_at >= 0 && k >= rise_at) begin
                dwt_valid = 1'b1;
                feat_vec  = {NF{32'hdead_beef}};
            end
            got = {feat_valid, busy, feat_last, feat_idx, feat_data};
            exp = {1'b1, 1'b1, 1'(k == NF-1), 5'(k), model_word(frame[k])};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s word%0d: got v%b b%b l%b i%0d d%h, want v1 b1 l%b i%0d d%h",
                         nm, k, feat_valid, busy, feat_last, feat_idx, feat_data,
                         k == NF-1, k, model_word(frame[k]));
            end
            tick();
            if (rdy) k++;
            cyc++;
        end
        feat_ready = 1'b0;
        n_cmp++;
        if (k != NF || feat_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s end: got words %0d v%b b%b, want words %0d v0 b0",
                     nm, k, feat_valid, busy, NF);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; dwt_valid = 1'b0; feat_ready = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({feat_valid, feat_last, busy, overrun, feat_idx, feat_data} !== '0) begin
            n_err++;
            $display("FAIL reset: got v%b l%b b%b o%b i%0d d%h, want all 0",
                     feat_valid, feat_last, busy, overrun, feat_idx, feat_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        for (int k = 0; k < NF; k++) frame[k] = 100 + k;
        start_frame();
        drain("basic", 0, -1);
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL basic_overrun: got %b, want 0", overrun);
        end
    endtask

    task automatic test_stall();
        rand_frame();
        start_frame();
        drain("stall", 1, -1);
    endtask

    task automatic test_norm();
        logic [DW-1:0] e0, e1;
`ifdef FEAT_NORM_EN
        e0 = 32'hFFFF_FFF0; e1 = 32'd15;
`else
        e0 = 32'hFFFF_FF00; e1 = 32'd255;
`endif
        rand_frame();
        frame[0] = -256; frame[1] = 255; frame[2] = -1;
        start_frame();
        n_cmp++;
        if (feat_data !== e0) begin
            n_err++;
            $display("FAIL norm_neg: got %h, want %h", feat_data, e0);
        end
        feat_ready = 1'b1; tick(); feat_ready = 1'b0;
        n_cmp++;
        if (feat_data !== e1) begin
            n_err++;
            $display("FAIL norm_pos: got %h, want %h", feat_data, e1);
        end
        tick();
        start_frame_after_reset_free();
    endtask

    // Drain whatever is left after the two explicit norm words via a fresh frame.
    task automatic start_frame_after_reset_free();
        feat_ready = 1'b1;
        repeat (NF - 1) tick();
        feat_ready = 1'b0;
        rand_frame();
        frame[3] = -256; frame[7] = 255;
        start_frame();
        drain("norm_rand", 2, -1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            start_frame();
            drain("random", 2, -1);
        end
    endtask

    task automatic test_held();
        int cnt = 0;
        rand_frame();
        for (int k = 0; k < NF; k++) feat_vec[k*DW +: DW] = frame[k];
        en = 1'b1; feat_ready = 1'b1; dwt_valid = 1'b1;
        repeat (100) begin
            if (feat_valid && feat_ready) cnt++;
            tick();
        end
        dwt_valid = 1'b0; feat_ready = 1'b0;
        tick();
        n_cmp++;
        if (cnt != NF || overrun !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL held: got words %0d o%b b%b, want words %0d o0 b0", cnt, overrun, busy, NF);
        end
    endtask

    task automatic test_en_low();
        en = 1'b0; dwt_valid = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (busy !== 1'b0 || feat_valid !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL en_low: got b%b v%b o%b, want b0 v0 o0", busy, feat_valid, overrun);
        end
        en = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL en_late: got busy %b, want 0", busy);
        end
        dwt_valid = 1'b0;
        tick();
    endtask

    task automatic test_overrun();
        rand_frame();
        start_frame();
        drain("overrun", 0, 5);
        dwt_valid = 1'b0;
        tick();
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_set: got %b, want 1", overrun);
        end
        rand_frame();
        start_frame();
        drain("after_overrun", 2, -1);
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_sticky: got %b, want 1", overrun);
        end
    endtask

    task automatic test_midreset();
        rand_frame();
        start_frame();
        feat_ready = 1'b1;
        repeat (10) tick();
        n_cmp++;
        if (feat_idx !== 5'd10 || feat_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_pos: got i%0d v%b, want i10 v1", feat_idx, feat_valid);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({feat_valid, feat_last, busy, overrun, feat_idx, feat_data} !== '0) begin
            n_err++;
            $display("FAIL midreset: got v%b l%b b%b o%b i%0d d%h, want all 0",
                     feat_valid, feat_last, busy, overrun, feat_idx, feat_data);
        end
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (feat_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_idle: got v%b b%b, want v0 b0", feat_valid, busy);
        end
        feat_ready = 1'b0;
        rand_frame();
        start_frame();
        drain("post_reset", 0, -1);
    endtask

    task automatic test_last_rise();
        rand_frame();
        start_frame();
        drain("last_rise", 0, NF-1);
        dwt_valid = 1'b0;
        tick();
        n_cmp++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL last_rise: got o%b b%b, want o1 b0", overrun, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_norm();
        test_random();
        test_held();
        test_en_low();
        test_overrun();
        test_midreset();
        test_last_rise();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
